// File: rtl/sequence_recorder_16x7.sv
// Records up to 16 single-button moves into a 16x7 register memory.
// A move is accepted only after all buttons have been released, so a held
// button is recorded once. Multi-button presses are rejected with a strobe.
module sequence_recorder_16x7 (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] botoes,
  input  logic       clear,
  input  logic [3:0] rd_address,
  output logic [6:0] data_out,
  output logic [4:0] count,
  output logic       full,
  output logic       write_pulse,
  output logic       invalid
);

  localparam logic [4:0] MaxCount = 5'd16;

  typedef enum logic [0:0] {
    StEsperaSolta,
    StEsperaJogada
  } state_e;

  state_e     state_q, state_d;
  logic [4:0] count_q, count_d;
  logic       write_pulse_q, write_pulse_d;
  logic       invalid_q, invalid_d;
  logic       mem_we;
  logic [6:0] mem_q [16];
  logic [6:0] data_out_q;
  logic       none_pressed;
  logic       one_hot;

  assign none_pressed = (botoes == 7'd0);
  // x & (x-1) clears the lowest set bit; zero result means at most one bit set.
  assign one_hot      = !none_pressed && ((botoes & (botoes - 7'd1)) == 7'd0);

  // State, move counter and event strobes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= StEsperaSolta;
      count_q       <= 5'd0;
      write_pulse_q <= 1'b0;
      invalid_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      write_pulse_q <= write_pulse_d;
      invalid_q     <= invalid_d;
    end
  end

  // Next-state decode: release gating, accept/reject of a press, clear priority.
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    write_pulse_d = 1'b0;
    invalid_d     = 1'b0;
    mem_we        = 1'b0;
    if (clear) begin
      state_d = StEsperaSolta;
      count_d = 5'd0;
    end else begin
      unique case (state_q)
        StEsperaSolta: begin
          if (none_pressed) state_d = StEsperaJogada;
        end
        StEsperaJogada: begin
          if (!none_pressed) begin
            state_d = StEsperaSolta;
            if (!one_hot) begin
              invalid_d = 1'b1;
            end else if (count_q < MaxCount) begin
              mem_we        = 1'b1;
              count_d       = count_q + 5'd1;
              write_pulse_d = 1'b1;
            end
            // One-hot press while full is silently dropped.
          end
        end
        default: state_d = StEsperaSolta;
      endcase
    end
  end

  // Move memory; writes land at the current count, cleared on reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        mem_q[i] <= 7'd0;
      end
    end else if (mem_we) begin
      mem_q[count_q[3:0]] <= botoes;
    end
  end

  // Registered read port; sees the pre-write contents on a same-edge write.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_out_q <= 7'd0;
    end else begin
      data_out_q <= mem_q[rd_address];
    end
  end

  assign data_out    = data_out_q;
  assign count       = count_q;
  assign full        = (count_q == MaxCount);
  assign write_pulse = write_pulse_q;
  assign invalid     = invalid_q;

endmodule

// File: tb/tb_sequence_recorder_16x7.sv
// Self-checking bench for sequence_recorder_16x7 with a behavioural model.
module tb_sequence_recorder_16x7;

  logic       clock = 1'b0;
  logic       reset;
  logic [6:0] botoes;
  logic       clear;
  logic [3:0] rd_address;
  logic [6:0] data_out;
  logic [4:0] count;
  logic       full;
  logic       write_pulse;
  logic       invalid;

  sequence_recorder_16x7 dut (
    .clock       (clock),
    .reset       (reset),
    .botoes      (botoes),
    .clear       (clear),
    .rd_address  (rd_address),
    .data_out    (data_out),
    .count       (count),
    .full        (full),
    .write_pulse (write_pulse),
    .invalid     (invalid)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Behavioural model: recorded moves, move count, and whether a release
  // has been seen since the last press (a press only counts when armed).
  logic [6:0] mem_m [16];
  int         exp_count;
  logic       exp_wp;
  logic       exp_inv;
  logic [6:0] exp_dout;
  bit         armed;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mem_m[i] = 7'd0;
    exp_count = 0;
    exp_wp    = 1'b0;
    exp_inv   = 1'b0;
    exp_dout  = 7'd0;
    armed     = 1'b0;
  endtask

  // Drive one cycle of inputs, advance the model, return 1ns after the edge.
  task automatic tick(input logic [6:0] b, input logic clr, input logic [3:0] addr);
    int pop;
    botoes     = b;
    clear      = clr;
    rd_address = addr;
    pop        = $countones(b);
    exp_dout   = mem_m[addr];
    exp_wp     = 1'b0;
    exp_inv    = 1'b0;
    if (clr) begin
      exp_count = 0;
      armed     = 1'b0;
    end else if (!armed) begin
      armed = (b == 7'd0);
    end else if (b != 7'd0) begin
      armed = 1'b0;
      if (pop > 1) begin
        exp_inv = 1'b1;
      end else if (exp_count < 16) begin
        mem_m[exp_count] = b;
        exp_count++;
        exp_wp = 1'b1;
      end
    end
    @(posedge clock);
    #1;
  endtask

  function automatic logic [6:0] rand_one_hot();
    logic [6:0] one;
    one = 7'd1;
    return one << $urandom_range(0, 6);
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    botoes = 7'd0;
    clear = 1'b0;
    rd_address = 4'd0;
    model_reset();
    #3;
    checks++;
    if (count !== 5'd0 || full !== 1'b0) begin
      errors++;
      $display("FAIL reset_count got count=%0d full=%0b exp 0/0", count, full);
    end
    checks++;
    if (write_pulse !== 1'b0 || invalid !== 1'b0 || data_out !== 7'd0) begin
      errors++;
      $display("FAIL reset_out got wp=%0b inv=%0b dout=%b exp 0/0/0", write_pulse, invalid,
               data_out);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    for (int a = 0; a < 16; a++) begin
      tick(7'd0, 1'b0, a[3:0]);
      checks++;
      if (data_out !== 7'd0) begin
        errors++;
        $display("FAIL reset_mem addr=%0d got=%b exp=0000000", a, data_out);
      end
    end
  endtask

  task automatic test_single_press();
    tick(7'b0010000, 1'b0, 4'd0);
    checks++;
    if (write_pulse !== 1'b1 || count !== 5'd1) begin
      errors++;
      $display("FAIL single_accept got wp=%0b count=%0d exp 1/1", write_pulse, count);
    end
    for (int i = 0; i < 2; i++) begin
      tick(7'b0010000, 1'b0, 4'd0);
      checks++;
      if (write_pulse !== 1'b0 || count !== 5'd1) begin
        errors++;
        $display("FAIL single_hold got wp=%0b count=%0d exp 0/1", write_pulse, count);
      end
    end
    tick(7'd0, 1'b0, 4'd0);
    tick(7'd0, 1'b0, 4'd0);
    checks++;
    if (data_out !== 7'b0010000 || data_out !== exp_dout) begin
      errors++;
      $display("FAIL single_read got=%b exp=0010000", data_out);
    end
  endtask

  task automatic test_fill();
    while (exp_count < 16) begin
      tick(rand_one_hot(), 1'b0, 4'd0);
      checks++;
      if (write_pulse !== exp_wp || count !== exp_count[4:0] || invalid !== 1'b0) begin
        errors++;
        $display("FAIL fill_press got wp=%0b count=%0d inv=%0b exp %0b/%0d/0", write_pulse,
                 count, invalid, exp_wp, exp_count);
      end
      tick(7'd0, 1'b0, 4'd0);
    end
    checks++;
    if (full !== 1'b1 || count !== 5'd16) begin
      errors++;
      $display("FAIL fill_full got full=%0b count=%0d exp 1/16", full, count);
    end
    tick(7'b0000001, 1'b0, 4'd0);
    checks++;
    if (write_pulse !== 1'b0 || invalid !== 1'b0 || count !== 5'd16 || full !== 1'b1) begin
      errors++;
      $display("FAIL fill_17th got wp=%0b inv=%0b count=%0d full=%0b exp 0/0/16/1",
               write_pulse, invalid, count, full);
    end
    tick(7'd0, 1'b0, 4'd0);
    for (int a = 0; a < 16; a++) begin
      tick(7'd0, 1'b0, a[3:0]);
      checks++;
      if (data_out !== exp_dout) begin
        errors++;
        $display("FAIL fill_read addr=%0d got=%b exp=%b", a, data_out, exp_dout);
      end
    end
  endtask

  task automatic test_invalid();
    logic [6:0] v;
    tick(7'd0, 1'b1, 4'd0);
    tick(7'd0, 1'b0, 4'd0);
    tick(rand_one_hot(), 1'b0, 4'd0);
    tick(7'd0, 1'b0, 4'd0);
    tick(7'b0100010, 1'b0, 4'd0);
    checks++;
    if (invalid !== 1'b1 || write_pulse !== 1'b0 || count !== 5'd1) begin
      errors++;
      $display("FAIL invalid_press got inv=%0b wp=%0b count=%0d exp 1/0/1", invalid,
               write_pulse, count);
    end
    tick(7'b0100010, 1'b0, 4'd0);
    checks++;
    if (invalid !== 1'b0) begin
      errors++;
      $display("FAIL invalid_strobe got=%0b exp=0", invalid);
    end
    tick(7'd0, 1'b0, 4'd0);
    v = rand_one_hot();
    tick(v, 1'b0, 4'd1);
    checks++;
    if (write_pulse !== 1'b1 || count !== 5'd2) begin
      errors++;
      $display("FAIL invalid_next got wp=%0b count=%0d exp 1/2", write_pulse, count);
    end
    tick(7'd0, 1'b0, 4'd1);
    checks++;
    if (data_out !== v) begin
      errors++;
      $display("FAIL invalid_addr got=%b exp=%b", data_out, v);
    end
  endtask

  task automatic test_clear();
    logic [6:0] v;
    while (exp_count < 5) begin
      tick(rand_one_hot(), 1'b0, 4'd0);
      tick(7'd0, 1'b0, 4'd0);
    end
    tick(7'b0000100, 1'b1, 4'd5);
    checks++;
    if (count !== 5'd0 || write_pulse !== 1'b0 || invalid !== 1'b0) begin
      errors++;
      $display("FAIL clear_press got count=%0d wp=%0b inv=%0b exp 0/0/0", count, write_pulse,
               invalid);
    end
    tick(7'd0, 1'b0, 4'd5);
    checks++;
    if (data_out !== exp_dout) begin
      errors++;
      $display("FAIL clear_mem5 got=%b exp=%b", data_out, exp_dout);
    end
    v = (mem_m[0] == 7'b1000000) ? 7'b0000001 : 7'b1000000;
    tick(v, 1'b0, 4'd0);
    checks++;
    if (write_pulse !== 1'b1 || count !== 5'd1) begin
      errors++;
      $display("FAIL clear_rerecord got wp=%0b count=%0d exp 1/1", write_pulse, count);
    end
    tick(7'd0, 1'b0, 4'd0);
    checks++;
    if (data_out !== v) begin
      errors++;
      $display("FAIL clear_addr0 got=%b exp=%b", data_out, v);
    end
  endtask

  task automatic test_read_before_write();
    logic [6:0] v;
    logic [6:0] old;
    tick(rand_one_hot(), 1'b0, 4'd0);
    tick(7'd0, 1'b0, 4'd0);
    old = mem_m[2];
    v = (old == 7'b0000001) ? 7'b1000000 : 7'b0000001;
    tick(v, 1'b0, 4'd2);
    checks++;
    if (data_out !== old || write_pulse !== 1'b1) begin
      errors++;
      $display("FAIL rbw_old got dout=%b wp=%0b exp %b/1", data_out, write_pulse, old);
    end
    tick(7'd0, 1'b0, 4'd2);
    checks++;
    if (data_out !== v) begin
      errors++;
      $display("FAIL rbw_new got=%b exp=%b", data_out, v);
    end
  endtask

  task automatic test_reset_mid();
    tick(7'd0, 1'b1, 4'd0);
    tick(7'd0, 1'b0, 4'd0);
    for (int i = 0; i < 2; i++) begin
      tick(rand_one_hot(), 1'b0, 4'd0);
      tick(7'd0, 1'b0, 4'd0);
    end
    tick(7'b0000010, 1'b0, 4'd0);
    tick(7'b0000010, 1'b0, 4'd0);
    checks++;
    if (count !== 5'd3) begin
      errors++;
      $display("FAIL rstmid_setup got count=%0d exp=3", count);
    end
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if (count !== 5'd0 || full !== 1'b0 || write_pulse !== 1'b0 || invalid !== 1'b0 ||
        data_out !== 7'd0) begin
      errors++;
      $display("FAIL rstmid_async got count=%0d full=%0b wp=%0b inv=%0b dout=%b exp all 0",
               count, full, write_pulse, invalid, data_out);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(7'b0000010, 1'b0, 4'd1);
      checks++;
      if (write_pulse !== 1'b0 || count !== 5'd0 || data_out !== 7'd0) begin
        errors++;
        $display("FAIL rstmid_held got wp=%0b count=%0d dout=%b exp 0/0/0", write_pulse, count,
                 data_out);
      end
    end
    tick(7'd0, 1'b0, 4'd0);
    tick(7'b0000100, 1'b0, 4'd0);
    checks++;
    if (write_pulse !== 1'b1 || count !== 5'd1) begin
      errors++;
      $display("FAIL rstmid_after got wp=%0b count=%0d exp 1/1", write_pulse, count);
    end
  endtask

  task automatic test_random();
    logic [6:0] b;
    int         r;
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 99);
      if (r < 45) b = 7'd0;
      else if (r < 80) b = rand_one_hot();
      else b = 7'($urandom);
      tick(b, ($urandom_range(0, 99) == 0), 4'($urandom));
      checks++;
      if (write_pulse !== exp_wp || invalid !== exp_inv || count !== exp_count[4:0] ||
          full !== (exp_count == 16) || data_out !== exp_dout) begin
        errors++;
        $display("FAIL random n=%0d got wp=%0b inv=%0b cnt=%0d full=%0b dout=%b exp %0b/%0b/%0d/%0b/%b",
                 n, write_pulse, invalid, count, full, data_out, exp_wp, exp_inv, exp_count,
                 (exp_count == 16), exp_dout);
      end
      checks++;
      if (write_pulse === 1'b1 && invalid === 1'b1) begin
        errors++;
        $display("FAIL random_excl n=%0d got wp=1 inv=1 exp not both", n);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_fill();
    test_invalid();
    test_clear();
    test_read_before_write();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sequence_recorder_16x7.md
SEQUENCE_RECORDER_16X7 -- requirements
Module: sequence_recorder_16x7

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset: clock input 1 (all state updates on rising edge); reset input 1 (asynchronous, active-high).
REQ-002 SHALL have port botoes, input, 7 bits: player buttons, already synchronous to clock; bit i high = button i pressed.
REQ-003 SHALL have port clear, input, 1 bit: synchronous restart of recording; memory contents are kept.
REQ-004 SHALL have port rd_address, input, 4 bits: read address into the recorded sequence.
REQ-005 SHALL have port data_out, output, 7 bits: registered read data, one-hot play format (bit 6..0), index 0 = first move.
REQ-006 SHALL have port count, output, 5 bits: number of moves stored, range 0..16.
REQ-007 SHALL have port full, output, 1 bit: high when count == 16.
REQ-008 SHALL have port write_pulse, output, 1 bit: one-cycle strobe after each accepted move.
REQ-009 SHALL have port invalid, output, 1 bit: one-cycle strobe after a rejected multi-button press.

Function
REQ-010 SHALL contain a 16x7 register memory, written only by this block.
REQ-011 SHALL implement FSM states ESPERA_SOLTA (wait all released) and ESPERA_JOGADA (wait press).
REQ-012 In ESPERA_SOLTA, SHALL move to ESPERA_JOGADA on the edge where botoes == 7'b0000000, else stay.
REQ-013 In ESPERA_JOGADA with botoes == 0, SHALL stay with no side effects.
REQ-014 In ESPERA_JOGADA with botoes exactly one-hot and count < 16, on that edge SHALL: write mem[count[3:0]] <= botoes; count <= count+1; write_pulse <= 1; go to ESPERA_SOLTA.
REQ-015 In ESPERA_JOGADA with two or more bits of botoes set, SHALL: not write; leave count unchanged; set invalid <= 1; go to ESPERA_SOLTA.
REQ-016 In ESPERA_JOGADA with a one-hot press and count == 16, SHALL ignore the press: no write, no strobe, go to ESPERA_SOLTA.
REQ-017 write_pulse and invalid SHALL each be high for exactly one cycle per event and never high together.
REQ-018 full SHALL be decoded from the count register (count == 16); count SHALL saturate at 16 and never wrap.
REQ-019 On every edge, data_out SHALL load mem[rd_address] (1-cycle read latency).
REQ-020 When a read and a write target the same address on the same edge, data_out SHALL return the old content (read-before-write).
REQ-021 clear == 1 SHALL take priority over a press on the same edge: count <= 0; write_pulse <= 0; invalid <= 0; state <= ESPERA_SOLTA; no write; memory and data_out read path unaffected.
REQ-022 A press held across many cycles SHALL be recorded once; a new move requires release (botoes == 0) first.

Reset
REQ-023 On reset assertion, the block SHALL immediately (asynchronously) set: state = ESPERA_SOLTA; count = 0; full = 0; write_pulse = 0; invalid = 0; data_out = 7'b0000000; all 16 memory words = 7'b0000000.
REQ-024 Reset asserted mid-recording SHALL discard the sequence; after release, buttons still held SHALL be ignored until botoes == 0.

Verification
REQ-025 Reset, botoes=0, press 7'b0010000 for 3 cycles, release -> one write_pulse, count=1, rd_address=0 gives data_out=7'b0010000 one cycle later.
REQ-026 Record 16 one-hot moves (e.g. 7'b0100000, 7'b0001000, ...), then press 7'b0000001 -> full=1 after 16th, 17th press gives no write_pulse, count stays 16, all 16 words read back correctly.
REQ-027 From ESPERA_JOGADA press 7'b0100010 -> invalid high one cycle, write_pulse low, count unchanged; next valid press is stored at the same address.
REQ-028 clear=1 on the same edge as press 7'b0000100 with count=5 -> count=0, no write_pulse, mem[5] unchanged; re-recording overwrites from address 0.
REQ-029 Reset asserted while 7'b0000010 is held with count=3 -> outputs zero at once; after deassert with button still held, no write until release then press.
REQ-030 Write to address 2 and rd_address=2 on the same edge -> data_out shows old value, new value on the next cycle.
